decoder_scan_nto2n: RTL
=======================

// Module: decoder_scan_nto2n
// PURPOSE
//   Registered, parametrised N-to-2^N one-hot decoder: successor to the 2-to-4 enable/select decoder.
//   Adds a selectable auto-scan mode: an internal prescaled counter walks the active output line for
//   display-digit / row multiplexing. Sits between control logic and multiplexed drivers.
//   Output polarity is runtime-selectable.
// PARAMETERS
//   N     2   select width; OUTS = 2**N output lines (N >= 1)
//   DIV   4   scan prescaler: clock cycles per scan position (DIV >= 1)
// PORTS
//   clk    in   1     system clock, rising edge
//   rst_n  in   1     asynchronous reset, active-low
//   w      in   N     direct-mode select code
//   S      in   1     polarity: 0 = active-high one-hot, 1 = active-low one-cold
//   En     in   1     enable; 0 forces all outputs inactive
//   mode   in   1     0 = direct decode of w, 1 = auto-scan
//   y      out  OUTS  decoded lines (registered)
//   idx    out  N     index of the line currently asserted (registered)
//   wrap   out  1     1-cycle pulse when the scan index wraps OUTS-1 -> 0
// BEHAVIOUR
//   - Reset (async, rst_n=0): y=0, idx=0, wrap=0, prescaler=0, polarity reg=0, state=IDLE.
//   - All inputs are sampled on clk; y, idx and wrap are registered. Latency from w/S/En/mode to y is 1 cycle.
//   - Inactive level of every line = sampled S. Active line = ~S. Applies to IDLE and BLANK too.
//   - States: IDLE (En=0), DIRECT (En=1, mode=0), SCAN (En=1, mode=1), BLANK (macro only).
//   - IDLE: y all inactive; idx, prescaler and wrap cleared to 0. Any state -> IDLE when En=0.
//   - DIRECT: idx<=w; y<=onehot(w) with polarity applied; prescaler held at 0; wrap=0.
//   - SCAN: prescaler counts 0..DIV-1. At DIV-1 it returns to 0 and idx advances by 1.
//     idx wraps OUTS-1 -> 0 with wrap=1 for exactly that cycle. y is onehot(idx) with polarity applied.
//   - DIV=1: idx advances every cycle; wrap then fires every OUTS cycles.
//   - Entry into SCAN (from IDLE or DIRECT) starts at idx=0, prescaler=0. First advance is DIV cycles later.
//   - mode change SCAN->DIRECT mid-scan takes effect on the next edge; the prescaler is cleared.
//   - En and mode changing in the same cycle: En has priority (IDLE).
//   - S toggled mid-operation: the new polarity is visible on y 1 cycle later; idx and the prescaler are unaffected.
//   - Async reset mid-scan: outputs go to reset values immediately, with no wrap pulse.
// CONFIGURATION
//   BLANK_GAP_EN defined:
//     - SCAN inserts one BLANK cycle between consecutive scan positions, including across the wrap.
//     - BLANK: y all inactive, idx holds the previous value.
//     - Period per position is DIV+1 cycles. wrap asserts on the cycle idx becomes 0, after the BLANK cycle.
//     - DIRECT is unaffected.
//   BLANK_GAP_EN undefined: no BLANK state; positions are back-to-back with no gap.
// STRUCTURE
//   - Package decoder_pkg:
//     - state encoding localparams (ST_IDLE, ST_DIRECT, ST_SCAN, ST_BLANK)
//     - clog2 function (for prescaler width)
//     - onehot(code, polarity) function
//   - Sub-module scan_prescaler (param DIV):
//     - inputs clr and run; output tick at count DIV-1
//     - instantiated once; the FSM, idx register and output register live in the top.
// TESTING
//   1 Reset: rst_n=0 while mode=1, En=1 -> y=0, idx=0, wrap=0 immediately (async). Release -> scan starts at idx 0.
//   2 Direct, N=2: En=1, mode=0, S=0, w=0..3 -> y=0001, 0010, 0100, 1000, each 1 cycle after w.
//     Repeat with S=1 -> y=1110, 1101, 1011, 0111.
//   3 Disable: En=0 with any w and S=1 -> y=1111 next cycle; with S=0 -> y=0000.
//   4 Scan, N=2, DIV=4: En=1, mode=1 -> idx 0,1,2,3,0 changing every 4 cycles.
//     wrap=1 only on the cycle idx returns to 0, once every 16 cycles.
//   5 Mid-scan switch at idx=2: mode->0 with w=1 -> y=0010 next cycle.
//     mode->1 again -> restart at idx=0 and hold 4 cycles.
//   6 BLANK_GAP_EN, DIV=1: y sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
//     wrap=1 together with the final 0001.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the N-to-2^N scan decoder.
// Codes up to MAX_N bits wide are supported by onehot().
package decoder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_DIRECT = 2'd1;
    localparam state_t ST_SCAN   = 2'd2;
    localparam state_t ST_BLANK  = 2'd3;

    localparam int MAX_N    = 6;
    localparam int MAX_OUTS = 2 ** MAX_N;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // pol=1 gives one-cold: every line high except the selected one
    function automatic logic [MAX_OUTS-1:0] onehot(
        input logic [MAX_N-1:0] code,
        input logic             pol
    );
        logic [MAX_OUTS-1:0] v;
        v       = '0;
        v[code] = 1'b1;
        return pol ? ~v : v;
    endfunction

endpackage

// File: rtl/decoder_scan_nto2n_prescaler.sv
// Scan prescaler: counts 0..DIV-1 while run_i, ticks on DIV-1.
// clr_i has priority and parks the count at 0.
module scan_prescaler
    import decoder_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic run_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = run_i && (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)       cnt_d = '0;
        else if (tick_o) cnt_d = '0;
        else if (run_i)  cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/decoder_scan_nto2n.sv
// Registered N-to-2^N decoder with direct and auto-scan modes.
// Optional BLANK_GAP_EN inserts one blank cycle between scan positions.
module decoder_scan_nto2n
    import decoder_pkg::*;
#(
    parameter int N   = 2,
    parameter int DIV = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    w,
    input  logic            S,
    input  logic            En,
    input  logic            mode,
    output logic [2**N-1:0] y,
    output logic [N-1:0]    idx,
    output logic            wrap
);

    localparam int OUTS = 2 ** N;

    state_t          state_q, state_d;
    logic [OUTS-1:0] y_q, y_d;
    logic [N-1:0]    idx_q, idx_d;
    logic            wrap_q, wrap_d;
    logic            clr, run, tick;
    logic [N-1:0]    idx_inc;

    function automatic logic [OUTS-1:0] lines(
        input logic [N-1:0] code,
        input logic         pol
    );
        return OUTS'(onehot(MAX_N'(code), pol));
    endfunction

    assign idx_inc = idx_q + 1'b1;

    scan_prescaler #(
        .DIV (DIV)
    ) u_presc (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr),
        .run_i  (run),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        y_d     = y_q;
        wrap_d  = 1'b0;
        clr     = 1'b1;
        run     = 1'b0;
        if (!En) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            y_d     = {OUTS{S}};
        end else if (!mode) begin
            state_d = ST_DIRECT;
            idx_d   = w;
            y_d     = lines(w, S);
        end else if (state_q == ST_SCAN) begin
            clr = 1'b0;
            run = 1'b1;
            y_d = lines(idx_q, S);
            if (tick) begin
`ifdef BLANK_GAP_EN
                state_d = ST_BLANK;
                y_d     = {OUTS{S}};
`else
                idx_d  = idx_inc;
                wrap_d = &idx_q;
                y_d    = lines(idx_inc, S);
`endif
            end
`ifdef BLANK_GAP_EN
        end else if (state_q == ST_BLANK) begin
            // prescaler stays cleared so the next position gets DIV cycles
            state_d = ST_SCAN;
            idx_d   = idx_inc;
            wrap_d  = &idx_q;
            y_d     = lines(idx_inc, S);
`endif
        end else begin
            state_d = ST_SCAN;
            idx_d   = '0;
            y_d     = lines('0, S);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            y_q     <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
        end
    end

    assign y    = y_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule
